// File: rtl/fp_norm_pkg.sv
// Shared state encoding, rounding-mode codes and IEEE-754 binary32 constants
// for the FP add/sub normalize-and-round stage.
package fp_norm_pkg;

    localparam int EXPI_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int EXP_MAX = 255;
    localparam int BIAS    = 127;

    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] INF    = 32'h7F80_0000;
    localparam logic [31:0] MAXFIN = 32'h7F7F_FFFF;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    // Reserved encodings 101-111 fall back to round-to-nearest-even.
    function automatic logic [2:0] legal_rm(input logic [2:0] rm);
        return (rm > RM_RMM) ? RM_RNE : rm;
    endfunction

endpackage

// File: rtl/fp_norm_round_r4_inc.sv
// Combinational round-increment decision from sign, lsb, guard, sticky and mode.
module fp_round_inc
    import fp_norm_pkg::*;
(
    input  logic       i_sign,
    input  logic       i_lsb,
    input  logic       i_g,
    input  logic       i_s,
    input  logic [2:0] i_rm,
    output logic       o_inc
);

    always_comb begin
        o_inc = 1'b0;
        case (i_rm)
            RM_RTZ:  o_inc = 1'b0;
            RM_RDN:  o_inc = i_sign & (i_g | i_s);
            RM_RUP:  o_inc = ~i_sign & (i_g | i_s);
            RM_RMM:  o_inc = i_g;
            default: o_inc = i_g & (i_s | i_lsb);
        endcase
    end

endmodule

// File: rtl/fp_norm_round_r4.sv
// Normalize, round and pack the FP add/sub mantissa sum into binary32.
// Define FNORM_SHIFT4_EN to let NORM skip 4 leading zeros per cycle.
module fp_norm_round_r4
    import fp_norm_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_res,
    input  logic              carry,
    input  logic [MANT_W-1:0] mantissa_sum,
    input  logic              sticky_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [2:0]        rm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       result,
    output logic [4:0]        flags
);

    localparam int LSB_POS = MANT_W - 24;
    localparam int G_POS   = MANT_W - 25;

    localparam logic signed [EXPI_W-1:0] EXP_ONE  = EXPI_W'(1);
    localparam logic signed [EXPI_W-1:0] EXP_FOUR = EXPI_W'(4);
    localparam logic signed [EXPI_W-1:0] EXP_OVF  = EXPI_W'(EXP_MAX);

    state_t                    r_state;
    state_t                    w_next;
    logic                      r_sign;
    logic                      r_sticky;
    logic [MANT_W-1:0]         r_m;
    logic signed [EXPI_W-1:0]  r_exp;
    logic [2:0]                r_rm;
    logic [31:0]               r_result;
    logic [4:0]                r_flags;

    logic                      w_isZero;
    logic                      w_normExit;
    logic                      w_skip4;
    logic signed [EXPI_W-1:0]  w_expIn;
    logic                      w_lsb;
    logic                      w_g;
    logic                      w_s;
    logic                      w_inc;
    logic [24:0]               w_sum;
    logic signed [EXPI_W-1:0]  w_expFinal;
    logic                      w_nx;
    logic                      w_of;
    logic                      w_uf;
    logic                      w_ofInf;
    logic [31:0]               w_result;
    logic [4:0]                w_flags;

    assign w_isZero   = ~carry & ~sticky_in & (mantissa_sum == '0);
    assign w_expIn    = $signed({{(EXPI_W-EXP_W){1'b0}}, exp_in});
    assign w_normExit = r_m[MANT_W-1] | (r_exp <= EXP_ONE);

`ifdef FNORM_SHIFT4_EN
    assign w_skip4 = (r_m[MANT_W-1 -: 4] == 4'b0000) && (r_exp > EXP_FOUR);
`else
    assign w_skip4 = 1'b0;
`endif

    assign w_lsb = r_m[LSB_POS];
    assign w_g   = r_m[G_POS];
    assign w_s   = (|r_m[G_POS-1:0]) | r_sticky;

    fp_round_inc u_round_inc (
        .i_sign (r_sign),
        .i_lsb  (w_lsb),
        .i_g    (w_g),
        .i_s    (w_s),
        .i_rm   (r_rm),
        .o_inc  (w_inc)
    );

    assign w_sum = {1'b0, r_m[MANT_W-1:LSB_POS]} + {24'b0, w_inc};

    // A subnormal (no hidden bit) that rounds up into bit 23 becomes exponent 1.
    always_comb begin
        w_expFinal = '0;
        w_nx       = 1'b0;
        w_of       = 1'b0;
        w_uf       = 1'b0;
        w_ofInf    = 1'b0;
        w_result   = '0;
        w_flags    = '0;

        if (r_m[MANT_W-1]) begin
            w_expFinal = r_exp + $signed({{(EXPI_W-1){1'b0}}, w_sum[24]});
        end else begin
            w_expFinal = $signed({{(EXPI_W-1){1'b0}}, w_sum[23]});
        end

        w_nx    = w_g | w_s;
        w_of    = (w_expFinal >= EXP_OVF);
        w_uf    = w_nx & (w_expFinal == '0);
        w_ofInf = (r_rm == RM_RNE) | (r_rm == RM_RMM) |
                  ((r_rm == RM_RUP) & ~r_sign) | ((r_rm == RM_RDN) & r_sign);

        if (w_of) begin
            w_result         = w_ofInf ? {r_sign, INF[30:0]} : {r_sign, MAXFIN[30:0]};
            w_flags[FLAG_OF] = 1'b1;
            w_flags[FLAG_NX] = 1'b1;
        end else begin
            w_result         = {r_sign, w_expFinal[EXP_W-1:0], w_sum[22:0]};
            w_flags[FLAG_UF] = w_uf;
            w_flags[FLAG_NX] = w_nx;
        end
        w_flags[FLAG_NV] = 1'b0;
        w_flags[FLAG_DZ] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_isZero) begin
                        w_next = DONE;
                    end else if (carry) begin
                        w_next = ROUND;
                    end else begin
                        w_next = NORM;
                    end
                end
            end
            NORM:    if (w_normExit) w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, normalization shifts and result latching.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign   <= 1'b0;
            r_sticky <= 1'b0;
            r_m      <= '0;
            r_exp    <= '0;
            r_rm     <= RM_RNE;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= sign_res;
                        r_rm   <= legal_rm(rm);
                        if (carry) begin
                            r_m      <= {1'b1, mantissa_sum[MANT_W-1:1]};
                            r_sticky <= sticky_in | mantissa_sum[0];
                            r_exp    <= w_expIn + EXP_ONE;
                        end else begin
                            r_m      <= mantissa_sum;
                            r_sticky <= sticky_in;
                            r_exp    <= w_expIn;
                        end
                        if (w_isZero) begin
                            r_result <= {(rm == RM_RDN), 31'b0};
                            r_flags  <= '0;
                        end
                    end
                end
                NORM: begin
                    if (!w_normExit) begin
                        if (w_skip4) begin
                            r_m   <= {r_m[MANT_W-5:0], 4'b0000};
                            r_exp <= r_exp - EXP_FOUR;
                        end else begin
                            r_m   <= {r_m[MANT_W-2:0], 1'b0};
                            r_exp <= r_exp - EXP_ONE;
                        end
                    end
                end
                ROUND: begin
                    r_result <= w_result;
                    r_flags  <= w_flags;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign flags     = r_flags;

endmodule
